branch_flush_unit: RTL and testbench
====================================

BRANCH_FLUSH_UNIT -- requirements
Module: branch_flush_unit

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 3: number of squash cycles after a redirect; legal range 1..7.
REQ-002 SHALL have parameter LDSEL_W, default 3: load-select width.
REQ-003 SHALL have parameter WBSEL_W, default 2: writeback-select width.
REQ-004 SHALL have parameter CNT_W, default 32: statistics counter width.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port inst  in  32  instruction currently in EX.
REQ-008 SHALL have ports br_eq, br_lt  in  1 each  comparator results for inst.
REQ-009 SHALL have port hold  in  1  EX instruction is a bubble/held; treat it as not executing.
REQ-010 SHALL have ports memrw_in [1:0], regwen_in [1], ldsel_in [LDSEL_W], wbsel_in [WBSEL_W], csrsel_in [1]  in  decode-stage controls.
REQ-011 SHALL have port memrw_ex  out  2  combinational squashed store control.
REQ-012 SHALL have ports regwen_ex, ldsel_ex, wbsel_ex, csrsel_ex  out  widths as inputs  registered controls toward writeback.
REQ-013 SHALL have port pc_sel  out  1  select redirect target PC.
REQ-014 SHALL have port flush_active  out  1  squash window open.
REQ-015 SHALL have port flush_cnt  out  3  remaining squash cycles.
REQ-016 SHALL have ports br_count, br_taken_count  out  CNT_W each  branch statistics.

Function
REQ-017 SHALL decode opcode = inst[6:2] and funct3 = inst[14:12].
REQ-018 SHALL compute taken combinationally; taken = 0 whenever hold or flush_active is 1.
REQ-019 SHALL set taken for B-type (11000) per funct3: 000 br_eq; 001 !br_eq; 100 and 110 br_lt; 101 and 111 !br_lt; 010 and 011 0 (defined, never X).
REQ-020 SHALL set taken = 1 for JAL (11011) and JALR (11001), and 0 for all other opcodes.
REQ-021 SHALL load flush_cnt with FLUSH_DEPTH on the edge where taken = 1; otherwise decrement it by 1 when nonzero; hold at 0 when zero.
REQ-022 SHALL drive flush_active = (flush_cnt != 0).
REQ-023 SHALL drive pc_sel = (flush_cnt == FLUSH_DEPTH): high exactly one cycle, the first cycle after detection.
REQ-024 SHALL, with FLUSH_DEPTH = 1, assert pc_sel and flush_active in the same single cycle.
REQ-025 SHALL never retrigger: a new jump or branch during the window is ignored and produces no extension.
REQ-026 SHALL drive memrw_ex = 0 when flush_active or hold is 1; otherwise memrw_ex = memrw_in.
REQ-027 SHALL register regwen_ex <= 0 when flush_active or hold is 1; otherwise regwen_ex <= regwen_in.
REQ-028 SHALL register ldsel_ex, wbsel_ex and csrsel_ex <= 0 when flush_active is 1; otherwise they take their inputs (hold does not clear them).

Reset
REQ-029 SHALL, on rst high, immediately set flush_cnt, regwen_ex, ldsel_ex, wbsel_ex, csrsel_ex, br_count and br_taken_count to 0, so that pc_sel = 0 and flush_active = 0.
REQ-030 SHALL abort any open squash window on reset with no residual pc_sel; the first post-reset edge behaves as idle.

Configuration
REQ-031 SHALL compile statistics only when macro BRANCH_FLUSH_STATS_EN is defined.
REQ-032 SHALL, with the macro defined, increment br_count on each edge where a B-type instruction is evaluated unsuppressed (hold = 0, flush_active = 0); counter saturates at all-ones.
REQ-033 SHALL, with the macro defined, increment br_taken_count on each such edge where the branch is taken (JAL/JALR excluded); counter saturates at all-ones.
REQ-034 SHALL, without the macro, keep both ports present, tie them to 0, and instantiate no counter flops.

Verification
REQ-035 SHALL verify: BEQ with br_eq = 1 -> pc_sel for 1 cycle; flush_active for 3 cycles; memrw_ex = 0 and regwen_ex cleared throughout.
REQ-036 SHALL verify: BNE with br_eq = 1 -> no pc_sel and no flush; controls pass through with 1-cycle register latency.
REQ-037 SHALL verify: JAL followed on the next cycle by JALR -> a single 3-cycle window; the JALR is ignored.
REQ-038 SHALL verify: hold = 1 with JAL in EX -> taken = 0, regwen_ex <= 0, memrw_ex = 0, and ldsel_ex takes ldsel_in.
REQ-039 SHALL verify: rst asserted asynchronously at flush_cnt = 2 -> all outputs 0 before the next edge.
REQ-040 SHALL verify, with BRANCH_FLUSH_STATS_EN and CNT_W = 4: 20 taken BLT -> br_count = br_taken_count = 15 (saturated).

Source files
------------

// File: rtl/branch_flush_unit.sv
// Branch/jump resolution and pipeline flush control for the EX stage.
// Resolves B-type, JAL and JALR in EX, redirects the PC for one cycle and
// squashes the following FLUSH_DEPTH cycles of control signals.
// Optional branch statistics are built only when BRANCH_FLUSH_STATS_EN is
// defined; otherwise br_count/br_taken_count are tied to zero.
module branch_flush_unit #(
   parameter int FLUSH_DEPTH = 3,
   parameter int LDSEL_W     = 3,
   parameter int WBSEL_W     = 2,
   parameter int CNT_W       = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        inst,
   input  logic               br_eq,
   input  logic               br_lt,
   input  logic               hold,
   input  logic [1:0]         memrw_in,
   input  logic               regwen_in,
   input  logic [LDSEL_W-1:0] ldsel_in,
   input  logic [WBSEL_W-1:0] wbsel_in,
   input  logic               csrsel_in,
   output logic [1:0]         memrw_ex,
   output logic               regwen_ex,
   output logic [LDSEL_W-1:0] ldsel_ex,
   output logic [WBSEL_W-1:0] wbsel_ex,
   output logic               csrsel_ex,
   output logic               pc_sel,
   output logic               flush_active,
   output logic [2:0]         flush_cnt,
   output logic [CNT_W-1:0]   br_count,
   output logic [CNT_W-1:0]   br_taken_count
);

   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [2:0] DEPTH     = 3'(FLUSH_DEPTH);

   logic [4:0] opcode;
   logic [2:0] funct3;
   logic       br_cond;
   logic       taken;
   logic       unused_inst_bits;

   assign opcode = inst[6:2];
   assign funct3 = inst[14:12];

   // Only opcode and funct3 matter here; the remaining bits are intentionally ignored.
   assign unused_inst_bits = ^{inst[31:15], inst[11:7], inst[1:0]};

   // Branch condition from funct3; reserved encodings resolve to not-taken.
   always_comb begin
      br_cond = 1'b0;
      case (funct3)
         3'b000:  br_cond = br_eq;
         3'b001:  br_cond = ~br_eq;
         3'b100:  br_cond = br_lt;
         3'b110:  br_cond = br_lt;
         3'b101:  br_cond = ~br_lt;
         3'b111:  br_cond = ~br_lt;
         default: br_cond = 1'b0;
      endcase
   end

   // Redirect decision; a held or already-squashed EX instruction never redirects.
   always_comb begin
      taken = 1'b0;
      if (!hold && !flush_active) begin
         case (opcode)
            OP_BRANCH: taken = br_cond;
            OP_JAL:    taken = 1'b1;
            OP_JALR:   taken = 1'b1;
            default:   taken = 1'b0;
         endcase
      end
   end

   // Squash window counter: loads on a redirect, then counts down to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_cnt <= 3'd0;
      end else if (taken) begin
         flush_cnt <= DEPTH;
      end else if (flush_cnt != 3'd0) begin
         flush_cnt <= flush_cnt - 3'd1;
      end
   end

   assign flush_active = (flush_cnt != 3'd0);
   assign pc_sel       = (flush_cnt == DEPTH);

   // Store control must be killed in the same cycle, so it stays combinational.
   assign memrw_ex = (flush_active || hold) ? 2'b00 : memrw_in;

   // Writeback-side controls; a held bubble must not write but may carry its selects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regwen_ex <= 1'b0;
         ldsel_ex  <= '0;
         wbsel_ex  <= '0;
         csrsel_ex <= 1'b0;
      end else begin
         regwen_ex <= (flush_active || hold) ? 1'b0 : regwen_in;
         if (flush_active) begin
            ldsel_ex  <= '0;
            wbsel_ex  <= '0;
            csrsel_ex <= 1'b0;
         end else begin
            ldsel_ex  <= ldsel_in;
            wbsel_ex  <= wbsel_in;
            csrsel_ex <= csrsel_in;
         end
      end
   end

`ifdef BRANCH_FLUSH_STATS_EN
   logic br_eval;

   assign br_eval = (opcode == OP_BRANCH) && !hold && !flush_active;

   // Saturating statistics: every evaluated conditional branch, and those taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_count       <= '0;
         br_taken_count <= '0;
      end else if (br_eval) begin
         if (br_count != '1) begin
            br_count <= br_count + CNT_W'(1);
         end
         if (br_cond && (br_taken_count != '1)) begin
            br_taken_count <= br_taken_count + CNT_W'(1);
         end
      end
   end
`else
   assign br_count       = '0;
   assign br_taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_flush_unit.sv
// Directed bench for branch_flush_unit: vector table plus reset and saturation sequences.
module tb_branch_flush_unit;

   localparam int LDSEL_W = 3;
   localparam int WBSEL_W = 2;
   localparam int CNT_W   = 4;

`ifdef BRANCH_FLUSH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam logic [31:0] I_ADDI = 32'h0000_0013;
   localparam logic [31:0] I_BEQ  = 32'h0000_0063;
   localparam logic [31:0] I_BNE  = 32'h0000_1063;
   localparam logic [31:0] I_BF2  = 32'h0000_2063;
   localparam logic [31:0] I_BLT  = 32'h0000_4063;
   localparam logic [31:0] I_BGE  = 32'h0000_5063;
   localparam logic [31:0] I_BLTU = 32'h0000_6063;
   localparam logic [31:0] I_BGEU = 32'h0000_7063;
   localparam logic [31:0] I_JAL  = 32'h0000_006F;
   localparam logic [31:0] I_JALR = 32'h0000_0067;

   logic               clk;
   logic               rst;
   logic [31:0]        inst;
   logic               br_eq;
   logic               br_lt;
   logic               hold;
   logic [1:0]         memrw_in;
   logic               regwen_in;
   logic [LDSEL_W-1:0] ldsel_in;
   logic [WBSEL_W-1:0] wbsel_in;
   logic               csrsel_in;
   logic [1:0]         memrw_ex;
   logic               regwen_ex;
   logic [LDSEL_W-1:0] ldsel_ex;
   logic [WBSEL_W-1:0] wbsel_ex;
   logic               csrsel_ex;
   logic               pc_sel;
   logic               flush_active;
   logic [2:0]         flush_cnt;
   logic [CNT_W-1:0]   br_count;
   logic [CNT_W-1:0]   br_taken_count;

   typedef struct {
      logic [31:0] inst;
      logic        eq;
      logic        lt;
      logic        hold;
      logic [1:0]  mi;
      logic        ri;
      logic [2:0]  li;
      logic [1:0]  wi;
      logic        ci;
      logic [1:0]  em;
      logic        er;
      logic [2:0]  el;
      logic [1:0]  ew;
      logic        ec;
      logic        epc;
      logic        efa;
      logic [2:0]  ecnt;
      logic        cbr;
      logic        cbrt;
   } vec_t;

   localparam int NVEC = 27;
   vec_t vecs [NVEC];

   int errors = 0;
   int checks = 0;
   logic [CNT_W-1:0] expBr  = '0;
   logic [CNT_W-1:0] expBrt = '0;

   branch_flush_unit #(
      .FLUSH_DEPTH(3),
      .LDSEL_W(LDSEL_W),
      .WBSEL_W(WBSEL_W),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .inst(inst),
      .br_eq(br_eq),
      .br_lt(br_lt),
      .hold(hold),
      .memrw_in(memrw_in),
      .regwen_in(regwen_in),
      .ldsel_in(ldsel_in),
      .wbsel_in(wbsel_in),
      .csrsel_in(csrsel_in),
      .memrw_ex(memrw_ex),
      .regwen_ex(regwen_ex),
      .ldsel_ex(ldsel_ex),
      .wbsel_ex(wbsel_ex),
      .csrsel_ex(csrsel_ex),
      .pc_sel(pc_sel),
      .flush_active(flush_active),
      .flush_cnt(flush_cnt),
      .br_count(br_count),
      .br_taken_count(br_taken_count)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic driveInputs(input logic [31:0] i, input logic eq, input logic lt, input logic h,
                              input logic [1:0] mi, input logic ri, input logic [2:0] li,
                              input logic [1:0] wi, input logic ci);
      inst      = i;
      br_eq     = eq;
      br_lt     = lt;
      hold      = h;
      memrw_in  = mi;
      regwen_in = ri;
      ldsel_in  = li;
      wbsel_in  = wi;
      csrsel_in = ci;
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      driveInputs(v.inst, v.eq, v.lt, v.hold, v.mi, v.ri, v.li, v.wi, v.ci);
      #1;
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, " br_count"}, 32'(br_count), STATS ? 32'(expBr) : 32'd0);
      checkOutput({tag, " br_taken_count"}, 32'(br_taken_count), STATS ? 32'(expBrt) : 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " pc_sel"}, 32'(pc_sel), 32'd0);
      checkOutput({tag, " flush_active"}, 32'(flush_active), 32'd0);
      checkOutput({tag, " flush_cnt"}, 32'(flush_cnt), 32'd0);
      checkOutput({tag, " regwen_ex"}, 32'(regwen_ex), 32'd0);
      checkOutput({tag, " ldsel_ex"}, 32'(ldsel_ex), 32'd0);
      checkOutput({tag, " wbsel_ex"}, 32'(wbsel_ex), 32'd0);
      checkOutput({tag, " csrsel_ex"}, 32'(csrsel_ex), 32'd0);
      checkOutput({tag, " memrw_ex"}, 32'(memrw_ex), 32'd0);
      checkOutput({tag, " br_count"}, 32'(br_count), 32'd0);
      checkOutput({tag, " br_taken_count"}, 32'(br_taken_count), 32'd0);
   endtask

   // Main sequence: table of single-cycle vectors, then reset and saturation corners.
   initial begin
      //            inst    eq   lt   hld  mi     ri   li    wi     ci   em     er   el    ew     ec   pc   fa   cnt   br   brt
      vecs[0]  = '{I_ADDI, 1'b0,1'b0,1'b0,2'b01,1'b1,3'd3,2'd1,1'b1,2'b01,1'b1,3'd3,2'd1,1'b1,1'b0,1'b0,3'd0,1'b0,1'b0};
      vecs[1]  = '{I_BNE,  1'b1,1'b0,1'b0,2'b10,1'b1,3'd5,2'd2,1'b0,2'b10,1'b1,3'd5,2'd2,1'b0,1'b0,1'b0,3'd0,1'b1,1'b0};
      vecs[2]  = '{I_BEQ,  1'b1,1'b0,1'b0,2'b01,1'b1,3'd2,2'd3,1'b1,2'b01,1'b1,3'd2,2'd3,1'b1,1'b1,1'b1,3'd3,1'b1,1'b1};
      vecs[3]  = '{I_ADDI, 1'b0,1'b0,1'b0,2'b11,1'b1,3'd7,2'd1,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b1,3'd2,1'b0,1'b0};
      vecs[4]  = '{I_JAL,  1'b0,1'b0,1'b0,2'b01,1'b1,3'd1,2'd1,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b1,3'd1,1'b0,1'b0};
      vecs[5]  = '{I_BEQ,  1'b1,1'b0,1'b0,2'b10,1'b1,3'd4,2'd2,1'b0,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0};
      vecs[6]  = '{I_ADDI, 1'b0,1'b0,1'b0,2'b01,1'b1,3'd6,2'd3,1'b1,2'b01,1'b1,3'd6,2'd3,1'b1,1'b0,1'b0,3'd0,1'b0,1'b0};
      vecs[7]  = '{I_JAL,  1'b0,1'b0,1'b1,2'b11,1'b1,3'd5,2'd2,1'b1,2'b00,1'b0,3'd5,2'd2,1'b1,1'b0,1'b0,3'd0,1'b0,1'b0};
      vecs[8]  = '{I_BLT,  1'b0,1'b1,1'b1,2'b10,1'b1,3'd1,2'd1,1'b0,2'b00,1'b0,3'd1,2'd1,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0};
      vecs[9]  = '{I_BF2,  1'b1,1'b1,1'b0,2'b10,1'b1,3'd2,2'd0,1'b0,2'b10,1'b1,3'd2,2'd0,1'b0,1'b0,1'b0,3'd0,1'b1,1'b0};
      vecs[10] = '{I_BGE,  1'b0,1'b0,1'b0,2'b01,1'b1,3'd3,2'd1,1'b0,2'b01,1'b1,3'd3,2'd1,1'b0,1'b1,1'b1,3'd3,1'b1,1'b1};
      vecs[11] = '{I_ADDI, 1'b0,1'b0,1'b0,2'b11,1'b1,3'd7,2'd3,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b1,3'd2,1'b0,1'b0};
      vecs[12] = '{I_ADDI, 1'b0,1'b0,1'b0,2'b11,1'b1,3'd7,2'd3,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b1,3'd1,1'b0,1'b0};
      vecs[13] = '{I_ADDI, 1'b0,1'b0,1'b0,2'b11,1'b1,3'd7,2'd3,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0};
      vecs[14] = '{I_ADDI, 1'b0,1'b0,1'b0,2'b10,1'b1,3'd7,2'd3,1'b1,2'b10,1'b1,3'd7,2'd3,1'b1,1'b0,1'b0,3'd0,1'b0,1'b0};
      vecs[15] = '{I_BLTU, 1'b0,1'b0,1'b0,2'b00,1'b0,3'd0,2'd0,1'b0,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b0,3'd0,1'b1,1'b0};
      vecs[16] = '{I_BGEU, 1'b0,1'b1,1'b0,2'b01,1'b1,3'd1,2'd1,1'b1,2'b01,1'b1,3'd1,2'd1,1'b1,1'b0,1'b0,3'd0,1'b1,1'b0};
      vecs[17] = '{I_BLTU, 1'b0,1'b1,1'b0,2'b01,1'b1,3'd2,2'd2,1'b0,2'b01,1'b1,3'd2,2'd2,1'b0,1'b1,1'b1,3'd3,1'b1,1'b1};
      vecs[18] = '{I_BNE,  1'b0,1'b0,1'b0,2'b11,1'b1,3'd3,2'd1,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b1,3'd2,1'b0,1'b0};
      vecs[19] = '{I_BNE,  1'b0,1'b0,1'b0,2'b11,1'b1,3'd3,2'd1,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b1,3'd1,1'b0,1'b0};
      vecs[20] = '{I_BNE,  1'b0,1'b0,1'b0,2'b11,1'b1,3'd3,2'd1,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0};
      vecs[21] = '{I_JAL,  1'b0,1'b0,1'b0,2'b11,1'b1,3'd1,2'd1,1'b1,2'b11,1'b1,3'd1,2'd1,1'b1,1'b1,1'b1,3'd3,1'b0,1'b0};
      vecs[22] = '{I_JALR, 1'b0,1'b0,1'b0,2'b10,1'b1,3'd2,2'd2,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b1,3'd2,1'b0,1'b0};
      vecs[23] = '{I_ADDI, 1'b0,1'b0,1'b0,2'b11,1'b1,3'd1,2'd1,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b1,3'd1,1'b0,1'b0};
      vecs[24] = '{I_ADDI, 1'b0,1'b0,1'b0,2'b11,1'b1,3'd1,2'd1,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0};
      vecs[25] = '{I_JALR, 1'b0,1'b0,1'b0,2'b01,1'b0,3'd4,2'd1,1'b0,2'b01,1'b0,3'd4,2'd1,1'b0,1'b1,1'b1,3'd3,1'b0,1'b0};
      vecs[26] = '{I_ADDI, 1'b0,1'b0,1'b0,2'b01,1'b1,3'd5,2'd1,1'b1,2'b00,1'b0,3'd0,2'd0,1'b0,1'b0,1'b1,3'd2,1'b0,1'b0};

      rst = 1'b1;
      driveInputs(I_ADDI, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 2'd0, 1'b0);
      #3;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         applyStimulus(vecs[i]);
         checkOutput({tag, " memrw_ex"}, 32'(memrw_ex), 32'(vecs[i].em));
         @(posedge clk);
         #1;
         if (vecs[i].cbr && (expBr != '1)) expBr = expBr + 1'b1;
         if (vecs[i].cbrt && (expBrt != '1)) expBrt = expBrt + 1'b1;
         checkOutput({tag, " regwen_ex"}, 32'(regwen_ex), 32'(vecs[i].er));
         checkOutput({tag, " ldsel_ex"}, 32'(ldsel_ex), 32'(vecs[i].el));
         checkOutput({tag, " wbsel_ex"}, 32'(wbsel_ex), 32'(vecs[i].ew));
         checkOutput({tag, " csrsel_ex"}, 32'(csrsel_ex), 32'(vecs[i].ec));
         checkOutput({tag, " pc_sel"}, 32'(pc_sel), 32'(vecs[i].epc));
         checkOutput({tag, " flush_active"}, 32'(flush_active), 32'(vecs[i].efa));
         checkOutput({tag, " flush_cnt"}, 32'(flush_cnt), 32'(vecs[i].ecnt));
         checkCounters(tag);
      end

      // Asynchronous reset in the middle of a window (flush_cnt = 2).
      @(negedge clk);
      driveInputs(I_ADDI, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd6, 2'd3, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkAllZero("async_rst");
      @(posedge clk);
      #1;
      checkAllZero("rst_held");
      @(negedge clk);
      rst = 1'b0;
      expBr  = '0;
      expBrt = '0;

      // First edge after reset behaves as idle: no residual redirect.
      driveInputs(I_ADDI, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 3'd3, 2'd2, 1'b1);
      #1;
      checkOutput("post_rst memrw_ex", 32'(memrw_ex), 32'h2);
      @(posedge clk);
      #1;
      checkOutput("post_rst pc_sel", 32'(pc_sel), 32'd0);
      checkOutput("post_rst flush_cnt", 32'(flush_cnt), 32'd0);
      checkOutput("post_rst regwen_ex", 32'(regwen_ex), 32'd1);
      checkOutput("post_rst ldsel_ex", 32'(ldsel_ex), 32'd3);

      // Twenty taken BLTs, each followed by its squash window; counters saturate.
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         driveInputs(I_BLT, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 2'd0, 1'b0);
         @(posedge clk);
         #1;
         if (expBr != '1) expBr = expBr + 1'b1;
         if (expBrt != '1) expBrt = expBrt + 1'b1;
         if (n == 0) begin
            checkOutput("blt0 pc_sel", 32'(pc_sel), 32'd1);
            checkCounters("blt0");
         end
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            driveInputs(I_BLT, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 2'd0, 1'b0);
            @(posedge clk);
            #1;
         end
         if (n == 0) begin
            checkOutput("blt0 window closed", 32'(flush_active), 32'd0);
         end
      end
      checkOutput("sat exp br", 32'(expBr), 32'd15);
      checkCounters("saturated");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
